i2c_bus_arbiter: RTL and testbench

Shares the single on-chip I2C transaction engine behind the I2C_SCL/I2C_SDA pins among several MCU-side requesters (sensor poller, EEPROM loader, PPS/timing config). It grants one requester at a time and starts the engine on the winner's behalf. It also supports multi-transaction bus locking and aborts a hung transfer through a watchdog. It sits between the requester blocks and the I2C byte engine inside godson_mcu_top.

---
 rtl/i2c_arb_pkg.sv | 25 ++
 rtl/arb_rr_pick.sv | 46 ++++
 rtl/i2c_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared constants and helpers for the I2C bus arbiter.
// Build option I2C_ARB_PRIO_EN selects fixed priority instead of round-robin.
package i2c_arb_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GRANT = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  // 1 ms at 50 MHz
  localparam int DEF_TIMEOUT_CYC = 50000;

  localparam int MAX_NREQ = 8;

  function automatic int onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner picker: round-robin from ptr_i+1, or lowest index
// when I2C_ARB_PRIO_EN is defined (the pointer port then disappears).
module arb_rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
`ifndef I2C_ARB_PRIO_EN
  input  logic [IDW-1:0]  ptr_i,
`endif
  output logic [NREQ-1:0] win_oh_o,
  output logic [IDW-1:0]  win_idx_o
);

`ifdef I2C_ARB_PRIO_EN
  always_comb begin
    win_oh_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        win_oh_o    = '0;
        win_oh_o[i] = 1'b1;
      end
    end
  end
`else
  // Scan farthest-first so the candidate nearest to ptr_i+1 is written last.
  always_comb begin
    int idx;
    win_oh_o = '0;
    idx      = 0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = int'(ptr_i) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_i[idx]) begin
        win_oh_o      = '0;
        win_oh_o[idx] = 1'b1;
      end
    end
  end
`endif

  assign win_idx_o = IDW'(onehot_to_idx(MAX_NREQ'(win_oh_o)));

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Grants the shared I2C engine to one requester at a time, with bus locking
// and a transfer watchdog. Define I2C_ARB_PRIO_EN for fixed-priority arbitration.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int IDW         = $clog2(NREQ)
) (
  input  logic            CLK50M,
  input  logic            rstn,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] lock_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  owner_o,
  output logic            busy_o,
  output logic            eng_start_o,
  input  logic            eng_done_i,
  output logic            eng_abort_o,
  output logic            timeout_o
);

  localparam int             CW       = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]  CNT_MAX  = '1;

  logic [2:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            start_q, start_d;
  logic            abort_q, abort_d;
  logic            timeout_q, timeout_d;
  logic [NREQ-1:0] win_oh;
  logic [IDW-1:0]  win_idx;

`ifndef I2C_ARB_PRIO_EN
  logic [IDW-1:0]  ptr_q, ptr_d;

  assign ptr_d = (state_q == ST_IDLE && |req_i) ? win_idx : ptr_q;

  // Pointer starts at the top requester so requester 0 wins first.
  always_ff @(posedge CLK50M or negedge rstn) begin
    if (!rstn) ptr_q <= IDW'(NREQ - 1);
    else       ptr_q <= ptr_d;
  end
`endif

  arb_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i     (req_i),
`ifndef I2C_ARB_PRIO_EN
    .ptr_i     (ptr_q),
`endif
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx)
  );

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    abort_d   = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (|req_i) begin
          gnt_d   = win_oh;
          owner_d = win_idx;
          start_d = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        // A completion in the expiry cycle takes precedence over the abort.
        if (eng_done_i) begin
          if (lock_i[owner_q]) begin
            state_d = ST_HOLD;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          gnt_d     = '0;
          abort_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_ABORT;
        end
      end
      ST_HOLD: begin
        cnt_d = cnt_inc;
        if (!lock_i[owner_q]) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          gnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (req_i[owner_q]) begin
          start_d = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK50M or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      abort_q   <= abort_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign owner_o     = owner_q;
  assign busy_o      = |gnt_q;
  assign eng_start_o = start_q;
  assign eng_abort_o = abort_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_i2c_bus_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req_i, lock_i, gnt_o;
  logic [1:0] owner_o;
  logic       busy_o, eng_start_o, eng_done_i, eng_abort_o, timeout_o;

  int checks = 0;
  int errors = 0;
  int txn_n  = 0;
  int last_owner;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(.NREQ(4), .TIMEOUT_CYC(100)) dut (
    .CLK50M      (clk),
    .rstn        (rstn),
    .req_i       (req_i),
    .lock_i      (lock_i),
    .gnt_o       (gnt_o),
    .owner_o     (owner_o),
    .busy_o      (busy_o),
    .eng_start_o (eng_start_o),
    .eng_done_i  (eng_done_i),
    .eng_abort_o (eng_abort_o),
    .timeout_o   (timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: nearest requester after the last owner (or lowest index).
  function automatic int exp_winner(input logic [3:0] r);
`ifdef I2C_ARB_PRIO_EN
    for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
    for (int off = 1; off <= 4; off++) begin
      int idx;
      idx = (last_owner + off) % 4;
      if (r[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic expect_grant(input string tag, input int w);
    txn_n++;
    $display("txn %0d %s: expect owner %0d, gnt=%b start=%b", txn_n, tag, w, gnt_o, eng_start_o);
    check({tag, "_start"}, eng_start_o, 1);
    check({tag, "_gnt"}, gnt_o, 32'(1) << w);
    check({tag, "_owner"}, owner_o, w);
    check({tag, "_busy"}, busy_o, 1);
    last_owner = w;
  endtask

  task automatic pulse_done();
    eng_done_i = 1'b1;
    tick();
    eng_done_i = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_i = '0;
    lock_i = '0;
    eng_done_i = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    last_owner = 3;
    tick();
  endtask

  initial begin
    int w, dly, abort_at;
    logic lk, again;
    logic [3:0] r;

    rstn = 1'b0;
    req_i = '0;
    lock_i = '0;
    eng_done_i = 1'b0;
    repeat (3) tick();
    check("rst_gnt", gnt_o, 0);
    check("rst_owner", owner_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_start", eng_start_o, 0);
    check("rst_abort", eng_abort_o, 0);
    check("rst_timeout", timeout_o, 0);
    rstn = 1'b1;
    last_owner = 3;
    tick();

    // Two requesters from reset; a done during GRANT must be ignored.
    req_i = 4'b0110;
    tick();
    expect_grant("t1", exp_winner(req_i));
    eng_done_i = 1'b1;
    tick();
    eng_done_i = 1'b0;
    check("t1_done_in_grant_gnt", gnt_o, 4'b0010);
    check("t1_start_one_cycle", eng_start_o, 0);
    repeat (4) tick();
    pulse_done();
    check("t1_release_gnt", gnt_o, 0);
    check("t1_release_busy", busy_o, 0);
    tick();
    expect_grant("t1_next", exp_winner(req_i));

    // All requesters held, one completion roughly every 20 cycles.
    req_i = 4'hF;
    for (int i = 0; i < 5; i++) begin
      repeat (19) tick();
      pulse_done();
      check("t2_release", gnt_o, 0);
      tick();
      expect_grant("t2", exp_winner(req_i));
    end
    req_i = '0;
    repeat (3) tick();
    pulse_done();
    check("t2_end_idle", gnt_o, 0);

    // Locked owner gets three consecutive starts, then releases to req 3.
    do_reset();
    req_i = 4'b1010;
    lock_i = 4'b0010;
    tick();
    expect_grant("t3_first", exp_winner(req_i));
    w = last_owner;
    for (int k = 0; k < 3; k++) begin
      repeat (5) tick();
      pulse_done();
      check("t3_hold_gnt", gnt_o, 32'(1) << w);
      check("t3_hold_start", eng_start_o, 0);
      if (k < 2) begin
        tick();
        expect_grant("t3_restart", w);
      end
    end
    lock_i = '0;
    tick();
    check("t3_unlock_gnt", gnt_o, 0);
    tick();
    expect_grant("t3_after_unlock", exp_winner(req_i));
    req_i = '0;
    repeat (2) tick();
    pulse_done();

    // Randomized transactions against the arbitration model.
    for (int it = 0; it < 40; it++) begin
      r = 4'($urandom_range(1, 15));
      req_i = r;
      tick();
      expect_grant("rnd", exp_winner(r));
      w = last_owner;
      req_i = 4'($urandom);
      dly = $urandom_range(1, 20);
      repeat (dly) tick();
      check("rnd_run_gnt", gnt_o, 32'(1) << w);
      lk = 1'($urandom_range(0, 1));
      lock_i = 4'($urandom);
      lock_i[w] = lk;
      pulse_done();
      if (lk) begin
        check("rnd_hold_gnt", gnt_o, 32'(1) << w);
        again = 1'($urandom_range(0, 1));
        if (again) begin
          req_i[w] = 1'b1;
          tick();
          expect_grant("rnd_restart", w);
          lock_i[w] = 1'b0;
          dly = $urandom_range(1, 10);
          repeat (dly) tick();
          pulse_done();
          check("rnd_restart_release", gnt_o, 0);
        end else begin
          lock_i[w] = 1'b0;
          tick();
          check("rnd_unlock_release", gnt_o, 0);
        end
      end else begin
        check("rnd_release", gnt_o, 0);
      end
    end
    lock_i = '0;

    // Watchdog: no completion, abort expected 101 cycles after the start.
    req_i = 4'b0100;
    tick();
    expect_grant("wd", exp_winner(req_i));
    req_i = '0;
    abort_at = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (eng_abort_o) begin
        abort_at = k;
        break;
      end
    end
    check("wd_abort_cycle", abort_at, 101);
    check("wd_timeout_set", timeout_o, 1);
    check("wd_abort_gnt", gnt_o, 0);
    check("wd_abort_busy", busy_o, 0);
    tick();
    check("wd_abort_one_cycle", eng_abort_o, 0);
    check("wd_timeout_held", timeout_o, 1);
    req_i = 4'b0001;
    tick();
    expect_grant("wd_after", exp_winner(req_i));
    req_i = '0;
    repeat (3) tick();
    pulse_done();
    check("wd_sticky", timeout_o, 1);
    check("wd_after_release", gnt_o, 0);

    // Completion in the exact expiry cycle: normal release, no abort.
    do_reset();
    req_i = 4'b0001;
    tick();
    expect_grant("exp", exp_winner(req_i));
    req_i = '0;
    repeat (100) tick();
    pulse_done();
    check("exp_no_abort", eng_abort_o, 0);
    check("exp_release_gnt", gnt_o, 0);
    check("exp_no_timeout", timeout_o, 0);
    tick();
    check("exp_no_abort_late", eng_abort_o, 0);
    check("exp_no_timeout_late", timeout_o, 0);

    // Asynchronous reset in RUN.
    req_i = 4'b0010;
    tick();
    expect_grant("ar", exp_winner(req_i));
    repeat (3) tick();
    #2 rstn = 1'b0;
    #1;
    check("ar_gnt", gnt_o, 0);
    check("ar_owner", owner_o, 0);
    check("ar_busy", busy_o, 0);
    check("ar_start", eng_start_o, 0);
    check("ar_abort", eng_abort_o, 0);
    check("ar_timeout", timeout_o, 0);
    req_i = 4'hF;
    repeat (2) tick();
    rstn = 1'b1;
    last_owner = 3;
    tick();
    expect_grant("ar_first", exp_winner(req_i));
    check("ar_first_is_req0", gnt_o, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
